// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares BRAM port B between the CPU datapath and a DMA/loader.
// Each requester gets a req/gnt/rvalid handshake. Only one transaction is in
// flight at a time. Every output comes from a register.
// Optional feature macro: MEM_ARB_RR_EN. When it is defined, ties are broken
// round-robin. When it is undefined, the CPU has fixed priority and no pointer
// register exists.

module mem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              winDma_q;
  logic              cpuGnt_q;
  logic              dmaGnt_q;
  logic              cpuRvalid_q;
  logic              dmaRvalid_q;
  logic              memEn_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic [DATA_W-1:0] cpuRdata_q;
  logic [DATA_W-1:0] dmaRdata_q;

  logic              anyReq_d;
  logic              pickDma_d;

`ifdef MEM_ARB_RR_EN
  // The pointer holds the requester that wins the next tie (1 = DMA). It starts at CPU.
  logic              rrDma_q;

  // After every grant the pointer moves to the requester that was not served, so held requests alternate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rrDma_q <= 1'b0;
    end else if (state_q == IDLE && anyReq_d) begin
      rrDma_q <= ~pickDma_d;
    end
  end

  // Choose the winner. A lone requester always wins, and a tie follows the pointer.
  always_comb begin
    anyReq_d  = i_cpu_req | i_dma_req;
    pickDma_d = i_dma_req & (~i_cpu_req | rrDma_q);
  end
`else
  // Choose the winner with fixed priority. The CPU wins every tie, so a busy CPU can starve the DMA.
  always_comb begin
    anyReq_d  = i_cpu_req | i_dma_req;
    pickDma_d = i_dma_req & ~i_cpu_req;
  end
`endif

  // Main FSM. Strobes are cleared by default every cycle, so gnt, rvalid, en and we are one-cycle pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      winDma_q    <= 1'b0;
      cpuGnt_q    <= 1'b0;
      dmaGnt_q    <= 1'b0;
      cpuRvalid_q <= 1'b0;
      dmaRvalid_q <= 1'b0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      cpuRdata_q  <= '0;
      dmaRdata_q  <= '0;
    end else begin
      cpuGnt_q    <= 1'b0;
      dmaGnt_q    <= 1'b0;
      cpuRvalid_q <= 1'b0;
      dmaRvalid_q <= 1'b0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (anyReq_d) begin
            winDma_q   <= pickDma_d;
            memEn_q    <= 1'b1;
            memWe_q    <= pickDma_d ? i_dma_we    : i_cpu_we;
            memAddr_q  <= pickDma_d ? i_dma_addr  : i_cpu_addr;
            memWdata_q <= pickDma_d ? i_dma_wdata : i_cpu_wdata;
            cpuGnt_q   <= ~pickDma_d;
            dmaGnt_q   <= pickDma_d;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (memWe_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= CNT_W'(RD_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (winDma_q) begin
              dmaRdata_q  <= i_mem_rdata;
              dmaRvalid_q <= 1'b1;
            end else begin
              cpuRdata_q  <= i_mem_rdata;
              cpuRvalid_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_cpu_gnt    = cpuGnt_q;
  assign o_dma_gnt    = dmaGnt_q;
  assign o_cpu_rvalid = cpuRvalid_q;
  assign o_dma_rvalid = dmaRvalid_q;
  assign o_cpu_rdata  = cpuRdata_q;
  assign o_dma_rdata  = dmaRdata_q;
  assign o_mem_en     = memEn_q;
  assign o_mem_we     = memWe_q;
  assign o_mem_addr   = memAddr_q;
  assign o_mem_wdata  = memWdata_q;
  assign o_busy       = (state_q != IDLE);

endmodule
